fifo_ctrl: RTL and testbench

//   Pointer/flag controller that turns the 2**W-entry register file into a FIFO.

---
 rtl/fifo_ctrl.sv | 65 ++++++
 tb/tb_fifo_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a 2**W-entry register file into a show-ahead FIFO.
// It holds no data; it drives the file's write strobe and both address ports.
module fifo_ctrl #(
    parameter int W         = 2,
    parameter int AF_THRESH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0]   DEPTH  = (W+1)'(1 << W);
    localparam logic [W:0]   AF_LVL = (W+1)'(AF_THRESH);
    localparam logic [W:0]   CNT_1  = (W+1)'(1);
    localparam logic [W-1:0] PTR_1  = W'(1);

    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic         push;
    logic         pop;

    // Flags decode straight from the registered count, so they carry no extra latency.
    assign full        = (count == DEPTH);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_LVL);

    // A full FIFO still takes a write when the same edge frees a slot.
    assign push   = wr & (~full | rd);
    assign pop    = rd & ~empty;
    assign wr_en  = push & ~reset;
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) w_ptr <= w_ptr + PTR_1;
            if (pop)  r_ptr <= r_ptr + PTR_1;
            case ({push, pop})
                2'b10:   count <= count + CNT_1;
                2'b01:   count <= count - CNT_1;
                default: count <= count;
            endcase
            // Rejected operations only leave a sticky error behind.
            if (wr & full & ~rd) overflow  <= 1'b1;
            if (rd & empty)      underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a local register file supplies r_data, and a table of
// per-cycle vectors plus hand-written sequences check pointers, count, flags and head.
module tb_fifo_ctrl;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr = 1'b0;
    logic         rd = 1'b0;
    logic         wr_en;
    logic [W-1:0] w_addr;
    logic [W-1:0] r_addr;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;
    logic [7:0]   w_data = 8'd0;
    logic [7:0]   mem [4];

    int checks = 0;
    int errors = 0;

    fifo_ctrl #(.W(W), .AF_THRESH(3)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .wr_en(wr_en),
        .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= w_data;
    end

    typedef struct {
        logic       rst, w, r;
        logic [7:0] data;
        logic       exp_wr_en;
        logic [2:0] cnt;
        logic [1:0] wa, ra;
        logic       fl, em, af, ov, un;
        logic       chk_head;
        logic [7:0] head;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_i, input logic w_i, input logic r_i, input int data_i,
                       input logic wen_i, input int cnt_i, input int wa_i, input int ra_i,
                       input logic fl_i, input logic em_i, input logic af_i,
                       input logic ov_i, input logic un_i, input logic ch_i, input int head_i);
        vec_t v;
        v.rst = rst_i; v.w = w_i; v.r = r_i; v.data = 8'(data_i);
        v.exp_wr_en = wen_i; v.cnt = 3'(cnt_i); v.wa = 2'(wa_i); v.ra = 2'(ra_i);
        v.fl = fl_i; v.em = em_i; v.af = af_i; v.ov = ov_i; v.un = un_i;
        v.chk_head = ch_i; v.head = 8'(head_i);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; wr = v.w; rd = v.r; w_data = v.data;
        #1;
        check($sformatf("v%0d wr_en", idx), int'(wr_en), int'(v.exp_wr_en));
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx), int'(count), int'(v.cnt));
        check($sformatf("v%0d w_addr", idx), int'(w_addr), int'(v.wa));
        check($sformatf("v%0d r_addr", idx), int'(r_addr), int'(v.ra));
        check($sformatf("v%0d full", idx), int'(full), int'(v.fl));
        check($sformatf("v%0d empty", idx), int'(empty), int'(v.em));
        check($sformatf("v%0d almost_full", idx), int'(almost_full), int'(v.af));
        check($sformatf("v%0d overflow", idx), int'(overflow), int'(v.ov));
        check($sformatf("v%0d underflow", idx), int'(underflow), int'(v.un));
        if (v.chk_head) check($sformatf("v%0d head", idx), int'(mem[r_addr]), int'(v.head));
    endtask

    initial begin
        //   rst w r data  wen cnt wa ra fl em af ov un chk head
        // reset then idle
        add(1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // fill with 100,101,110,120
        add(0, 1, 0, 100,  1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 100);
        add(0, 1, 0, 101,  1, 2, 2, 0, 0, 0, 0, 0, 0, 1, 100);
        add(0, 1, 0, 110,  1, 3, 3, 0, 0, 0, 1, 0, 0, 1, 100);
        add(0, 1, 0, 120,  1, 4, 0, 0, 1, 0, 1, 0, 0, 1, 100);
        // drain from full
        add(0, 0, 1, 0,    0, 3, 0, 1, 0, 0, 1, 0, 0, 1, 101);
        add(0, 0, 1, 0,    0, 2, 0, 2, 0, 0, 0, 0, 0, 1, 110);
        add(0, 0, 1, 0,    0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 120);
        add(0, 0, 1, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // refill, then push+pop while full
        add(0, 1, 0, 1,    1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 2,    1, 2, 2, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 3,    1, 3, 3, 0, 0, 0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 4,    1, 4, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        add(0, 1, 1, 5,    1, 4, 1, 1, 1, 0, 1, 0, 0, 1, 2);
        add(0, 1, 1, 6,    1, 4, 2, 2, 1, 0, 1, 0, 0, 1, 3);
        // write into full without pop: rejected, overflow sticks
        add(0, 1, 0, 7,    0, 4, 2, 2, 1, 0, 1, 1, 0, 1, 3);
        add(0, 0, 0, 0,    0, 4, 2, 2, 1, 0, 1, 1, 0, 1, 3);
        add(0, 0, 1, 0,    0, 3, 2, 3, 0, 0, 1, 1, 0, 1, 4);
        add(0, 0, 1, 0,    0, 2, 2, 0, 0, 0, 0, 1, 0, 1, 5);
        add(0, 0, 1, 0,    0, 1, 2, 1, 0, 0, 0, 1, 0, 1, 6);
        add(0, 0, 1, 0,    0, 0, 2, 2, 0, 1, 0, 1, 0, 0, 0);
        // wr+rd while empty: write taken, read rejected
        add(0, 1, 1, 8,    1, 1, 3, 2, 0, 0, 0, 1, 1, 1, 8);
        // count=2, then reset while wr=1
        add(0, 1, 0, 9,    1, 2, 0, 2, 0, 0, 0, 1, 1, 1, 8);
        add(1, 1, 0, 10,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) step(vecs[i], i);

        // Hand-written: plain pop on empty sets only underflow, which then persists.
        @(negedge clk); reset = 1'b0; wr = 1'b0; rd = 1'b1;
        @(posedge clk); #1;
        check("seq underflow set", int'(underflow), 1);
        check("seq r_addr held", int'(r_addr), 0);
        check("seq count held", int'(count), 0);
        @(negedge clk); rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("seq underflow sticky", int'(underflow), 1);
        check("seq overflow clear", int'(overflow), 0);

        // Hand-written: a write after the underflow still lands at address 0 and shows ahead.
        @(negedge clk); wr = 1'b1; w_data = 8'd42;
        @(posedge clk); #1;
        check("seq push count", int'(count), 1);
        check("seq push head", int'(mem[r_addr]), 42);
        check("seq push w_addr", int'(w_addr), 1);
        @(negedge clk); wr = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("seq reset underflow", int'(underflow), 0);
        check("seq reset empty", int'(empty), 1);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
